// File: rtl/muldiv_sequencer.sv
// ============================================================================
//  Module   : muldiv_sequencer
//  Purpose  : Iterative RV32M multiply/divide sequencer (shift-add multiply,
//             restoring divide). Optional build macro: MULDIV_ZERO_SKIP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Result
);

    localparam int c_CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                r_state, w_state_next;
    logic [2:0]            r_f3;
    logic                  r_neg;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [XLEN-1:0]       r_op;
    logic [2*XLEN-1:0]     r_acc;

    logic                  w_accept, w_is_div, w_signed_a, w_signed_b;
    logic                  w_neg_a, w_neg_b, w_div0, w_ovf, w_zskip, w_bypass;
    logic [XLEN-1:0]       w_mag_a, w_mag_b, w_bypass_val;
    logic [XLEN:0]         w_sum;
    logic [XLEN:0]         w_shift;
    logic [XLEN+1:0]       w_trial;
    logic [2*XLEN-1:0]     w_mul_next, w_div_next, w_prod;
    logic [XLEN-1:0]       w_quo, w_rem, w_fix;

    // ---------------- operand decode at start ----------------
    assign w_accept   = (r_state == S_IDLE) && start && !kill;
    assign w_is_div   = Funct3[2];
    assign w_signed_a = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                        (Funct3 == 3'b100) || (Funct3 == 3'b110);
    assign w_signed_b = (Funct3 == 3'b001) || (Funct3 == 3'b100) || (Funct3 == 3'b110);
    assign w_neg_a    = w_signed_a && SrcA[XLEN-1];
    assign w_neg_b    = w_signed_b && SrcB[XLEN-1];
    assign w_mag_a    = w_neg_a ? -SrcA : SrcA;
    assign w_mag_b    = w_neg_b ? -SrcB : SrcB;

    assign w_div0 = w_is_div && (SrcB == '0);
    assign w_ovf  = w_is_div && !Funct3[0] && (SrcA == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (SrcB == '1);
`ifdef MULDIV_ZERO_SKIP_EN
    assign w_zskip = !w_is_div && ((SrcA == '0) || (SrcB == '0));
`else
    assign w_zskip = 1'b0;
`endif
    assign w_bypass = w_div0 || w_ovf || w_zskip;

    // Funct3[1] separates REM/REMU from DIV/DIVU
    always_comb begin
        w_bypass_val = '0;
        if (w_div0)
            w_bypass_val = Funct3[1] ? SrcA : '1;
        else if (w_ovf)
            w_bypass_val = Funct3[1] ? '0 : SrcA;
    end

    // ---------------- iteration datapath ----------------
    assign w_sum      = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_op} : '0);
    assign w_mul_next = {w_sum, r_acc[XLEN-1:1]};

    assign w_shift    = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    assign w_trial    = {1'b0, w_shift} - {2'b00, r_op};
    assign w_div_next = w_trial[XLEN+1] ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                        : {w_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_quo  = r_neg ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_neg ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        w_fix = '0;
        if (r_f3[2])
            w_fix = r_f3[1] ? w_rem : w_quo;
        else
            w_fix = (r_f3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = (r_state != S_IDLE);
        done         = (r_state == S_DONE) && !kill;
        case (r_state)
            S_IDLE: if (w_accept) w_state_next = w_bypass ? S_DONE : S_CALC;
            S_CALC: if (r_cnt == '0) w_state_next = S_FIX;
            S_FIX:  w_state_next = S_DONE;
            S_DONE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (kill) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_f3   <= '0;
            r_neg  <= 1'b0;
            r_cnt  <= '0;
            r_op   <= '0;
            r_acc  <= '0;
            Result <= '0;
        end else if (w_accept) begin
            r_f3   <= Funct3;
            // quotient/product take signA^signB, remainder takes signA
            r_neg  <= (w_is_div && Funct3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
            r_cnt  <= c_CNT_W'(XLEN - 1);
            r_op   <= w_is_div ? w_mag_b : w_mag_a;
            r_acc  <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            if (w_bypass) Result <= w_bypass_val;
        end else if (!kill) begin
            if (r_state == S_CALC) begin
                r_acc <= r_f3[2] ? w_div_next : w_mul_next;
                if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            if (r_state == S_FIX) Result <= w_fix;
        end
    end

endmodule

`default_nettype wire
